// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline hazard-control signals between the datapath (master) and
// the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int STALL_W = 16
);
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rt;
    logic               ex_MemRead;
    logic [4:0]         ex_writeReg;
    logic               branch_taken;
    logic               mem_req;
    logic               dmem_ready;
    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_flush;
    logic               exmem_en;
    logic               memwb_en;
    logic               memwb_bubble;
    logic               err;
    logic [STALL_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_writeReg,
               branch_taken, mem_req, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en,
               memwb_en, memwb_bubble, err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_writeReg,
               branch_taken, mem_req, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en,
               memwb_en, memwb_bubble, err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// data-memory wait freezes with timeout, and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int STALL_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [STALL_W-1:0] r_stall;

    logic w_lu;
    logic w_mem_wait;
    logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush;
    logic w_exmem_en, w_memwb_en, w_memwb_bubble;

    always_comb begin
        w_lu = hz.ex_MemRead && (hz.ex_writeReg != 5'd0) &&
               ((hz.ex_writeReg == hz.id_rs) ||
                (hz.id_uses_rt && (hz.ex_writeReg == hz.id_rt)));
        // In MEM_WAIT the access is already outstanding, so mem_req is not re-examined
        w_mem_wait = !hz.dmem_ready &&
                     ((r_state == MEM_WAIT) || ((r_state == RUN) && hz.mem_req));
    end

    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_en     = 1'b1;
        w_memwb_en     = 1'b1;
        w_memwb_bubble = 1'b0;
        if (!rst_n || (r_state == ERR)) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_memwb_en     = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (w_mem_wait) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (w_lu) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else if (hz.branch_taken) begin
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_wait) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt >= CNT_W'(TIMEOUT)) begin
                        r_state <= ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (!w_pc_en && (r_stall != {STALL_W{1'b1}})) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign hz.pc_en        = w_pc_en;
    assign hz.ifid_en      = w_ifid_en;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.idex_flush   = w_idex_flush;
    assign hz.exmem_en     = w_exmem_en;
    assign hz.memwb_en     = w_memwb_en;
    assign hz.memwb_bubble = w_memwb_bubble;
    assign hz.err          = (r_state == ERR);
    assign hz.stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed bench for pipe_hazard_ctrl: a reference model pushes
// expected outputs into a queue, a separate monitor pops and compares them.
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT   = 15;
    localparam int STALL_W   = 6;
    localparam int MAX_STALL = (1 << STALL_W) - 1;

    typedef struct packed {
        logic [7:0]         ctrl;
        logic [STALL_W-1:0] stall;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t expQ[$];
    int   assertCount;
    int   failCount;
    int   cycleNo;
    bit   driverDone;

    int   unservedStreak;
    bit   dead;
    int   stallModel;

    pipe_hazard_ctrl_if #(.STALL_W(STALL_W)) hzIf ();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hzIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and record what the DUT must show.
    task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRt, input logic memRead, input logic [4:0] wr,
                                 input logic br, input logic req, input logic rdy);
        logic [7:0] e;
        logic       lu;
        logic       freeze;
        @(negedge clk);
        rst_n                = rst;
        hzIf.id_rs           = rs;
        hzIf.id_rt           = rt;
        hzIf.id_uses_rt      = usesRt;
        hzIf.ex_MemRead      = memRead;
        hzIf.ex_writeReg     = wr;
        hzIf.branch_taken    = br;
        hzIf.mem_req         = req;
        hzIf.dmem_ready      = rdy;
        lu     = memRead && (wr != 0) && ((wr == rs) || (usesRt && (wr == rt)));
        freeze = !rdy && ((unservedStreak > 0) || req);
        // bit order: pc_en ifid_en ifid_flush idex_flush exmem_en memwb_en memwb_bubble err
        if (!rst) begin
            dead = 0; unservedStreak = 0; stallModel = 0;
            e = 8'b0000_0010;
        end else if (dead) e = 8'b0000_0011;
        else if (freeze)   e = 8'b0000_0110;
        else if (lu)       e = 8'b0001_1100;
        else if (br)       e = 8'b1110_1100;
        else               e = 8'b1100_1100;
        expQ.push_back('{ctrl: e, stall: STALL_W'(stallModel)});
        if (rst) begin
            if (!e[7] && stallModel < MAX_STALL) stallModel++;
            if (!dead) begin
                if (freeze) begin
                    unservedStreak++;
                    if (unservedStreak > TIMEOUT) dead = 1;
                end else begin
                    unservedStreak = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input exp_t exp);
        logic [7:0] got;
        got = {hzIf.pc_en, hzIf.ifid_en, hzIf.ifid_flush, hzIf.idex_flush,
               hzIf.exmem_en, hzIf.memwb_en, hzIf.memwb_bubble, hzIf.err};
        assertCount++;
        if (got !== exp.ctrl) begin
            failCount++;
            $display("[TB] FAIL ctrl cycle %0d: got %b expected %b", cycleNo, got, exp.ctrl);
        end
        assertCount++;
        if (hzIf.stall_cycles !== exp.stall) begin
            failCount++;
            $display("[TB] FAIL stall_cycles cycle %0d: got %0d expected %0d",
                     cycleNo, hzIf.stall_cycles, exp.stall);
        end
    endtask

    // Monitor: every output observation is checked against the oldest expectation.
    initial begin
        cycleNo = 0;
        while (!driverDone) begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
                cycleNo++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount = 0; failCount = 0; driverDone = 0;
        dead = 0; unservedStreak = 0; stallModel = 0;
        rst_n = 1'b0;
        hzIf.id_rs = 0; hzIf.id_rt = 0; hzIf.id_uses_rt = 0; hzIf.ex_MemRead = 0;
        hzIf.ex_writeReg = 0; hzIf.branch_taken = 0; hzIf.mem_req = 0; hzIf.dmem_ready = 1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 5, 0, 0, 1, 5, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(1, 3, 7, 0, 1, 7, 0, 0, 1);
        applyStimulus(1, 3, 7, 1, 1, 7, 0, 0, 1);
        applyStimulus(1, 1, 2, 1, 0, 0, 1, 0, 1);
        applyStimulus(1, 4, 0, 0, 1, 4, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 5, 0, 0, 1, 5, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 5, 0, 0, 1, 5, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < TIMEOUT + 1; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 70; i++)
            applyStimulus(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                          1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                          1'($urandom), 1'($urandom));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 500; i++)
            applyStimulus(($urandom_range(0, 39) != 0), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7));
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #4;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        driverDone = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
